// File: rtl/ctrl_sequencer_pkg.sv
// Shared types, opcode constants and ALU-control table for the hardwired control unit.
// CTRL_MULDIV_EN adds the MUL/DIV opcodes and the T6 state.
package ctrl_pkg;

    localparam int OPC_MSB     = 31;
    localparam int RA_MSB      = 26;
    localparam int RB_MSB      = 22;
    localparam int RC_MSB      = 18;
    localparam int REG_FIELD_W = 4;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_HALT = 5'b11011;
`ifdef CTRL_MULDIV_EN
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
`endif

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
`ifdef CTRL_MULDIV_EN
        ST_T6,
`endif
        ST_HALT
    } state_t;

    function automatic logic [4:0] op_to_ctl(input logic [4:0] op);
        case (op)
            OP_ADD:  return 5'b00000;
            OP_SUB:  return 5'b00001;
            OP_AND:  return 5'b00010;
            OP_OR:   return 5'b00011;
            OP_SHR:  return 5'b00100;
            OP_SHL:  return 5'b00101;
            OP_ROR:  return 5'b00110;
            OP_ROL:  return 5'b00111;
`ifdef CTRL_MULDIV_EN
            OP_MUL:  return 5'b01000;
            OP_DIV:  return 5'b01001;
`endif
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic op_is_alu(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return 1'b1;
`ifdef CTRL_MULDIV_EN
            OP_MUL, OP_DIV:                 return 1'b1;
`endif
            default:                        return 1'b0;
        endcase
    endfunction

`ifdef CTRL_MULDIV_EN
    function automatic logic op_is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction
`endif

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Strobe and handshake bundle between the control sequencer and the datapath.
// CTRL_MULDIV_EN adds the ZHI_Out, LO_In and HI_In strobes.
interface ctrl_sequencer_if #(
    parameter int NREGS = 16,
    parameter int CTLW  = 5
);
    logic              Run;
    logic [31:0]       IR;
    logic              Mem_Ready;
    logic              PC_Out;
    logic              ZLO_Out;
    logic              MDR_Out;
    logic              MAR_In;
    logic              PC_In;
    logic              MDR_In;
    logic              IR_In;
    logic              Y_In;
    logic              Z_In;
    logic              IncPC;
    logic              Read;
    logic [NREGS-1:0]  R_In;
    logic [NREGS-1:0]  R_Out;
    logic [CTLW-1:0]   CONTROL;
    logic              Done;
    logic              Illegal;
    logic              Halted;
`ifdef CTRL_MULDIV_EN
    logic              ZHI_Out;
    logic              LO_In;
    logic              HI_In;
`endif

    modport master (
        input  Run, IR, Mem_Ready,
        output PC_Out, ZLO_Out, MDR_Out, MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In,
               IncPC, Read, R_In, R_Out, CONTROL, Done, Illegal, Halted
`ifdef CTRL_MULDIV_EN
      , output ZHI_Out, LO_In, HI_In
`endif
    );

    modport slave (
        output Run, IR, Mem_Ready,
        input  PC_Out, ZLO_Out, MDR_Out, MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In,
               IncPC, Read, R_In, R_Out, CONTROL, Done, Illegal, Halted
`ifdef CTRL_MULDIV_EN
      , input  ZHI_Out, LO_In, HI_In
`endif
    );

endinterface

// File: rtl/ctrl_sequencer_reg_select_encode.sv
// Picks Ra/Rb/Rc from the instruction and turns it into one-hot register load/drive buses.
// An index at or beyond NREGS selects no register.
module reg_select_encode
    import ctrl_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic [REG_FIELD_W-1:0] ra,
    input  logic [REG_FIELD_W-1:0] rb,
    input  logic [REG_FIELD_W-1:0] rc,
    input  logic                   gra,
    input  logic                   grb,
    input  logic                   grc,
    input  logic                   rin,
    input  logic                   rout,
    output logic [NREGS-1:0]       r_in,
    output logic [NREGS-1:0]       r_out
);

    logic [REG_FIELD_W-1:0] sel;

    always_comb begin
        sel   = '0;
        r_in  = '0;
        r_out = '0;
        if (gra)
            sel = ra;
        else if (grb)
            sel = rb;
        else if (grc)
            sel = rc;
        for (int i = 0; i < NREGS; i++) begin
            if (int'(sel) == i) begin
                r_in[i]  = rin;
                r_out[i] = rout;
            end
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired control unit: fetch T0-T2, decode, and T3-T5 execute for register ALU/shift ops.
// CTRL_MULDIV_EN enables MUL/DIV with an extra T6 cycle for the HI half of the result.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int OPW   = 5,
    parameter int CTLW  = 5
) (
    input  logic             Clock,
    input  logic             Clear,
    ctrl_sequencer_if.master bus
);

    state_t                 state;
    state_t                 state_next;
    logic                   stall_q;
    logic                   done_q;
    logic                   done_set;
    logic [CTLW-1:0]        ctl_q;
    logic [CTLW-1:0]        ctl_now;
    logic [OPW-1:0]         opcode;
    logic [REG_FIELD_W-1:0] ra;
    logic [REG_FIELD_W-1:0] rb;
    logic [REG_FIELD_W-1:0] rc;
    logic                   is_halt;
    logic                   is_alu;
    logic                   muldiv;
    logic                   gra;
    logic                   grb;
    logic                   grc;
    logic                   rin;
    logic                   rout;
    logic                   unused_ir_bits;

    assign opcode         = bus.IR[OPC_MSB -: OPW];
    assign ra             = bus.IR[RA_MSB -: REG_FIELD_W];
    assign rb             = bus.IR[RB_MSB -: REG_FIELD_W];
    assign rc             = bus.IR[RC_MSB -: REG_FIELD_W];
    assign unused_ir_bits = ^bus.IR[RC_MSB-REG_FIELD_W:0];
    assign is_halt        = (5'(opcode) == OP_HALT);
    assign is_alu         = op_is_alu(5'(opcode));
    assign ctl_now        = CTLW'(op_to_ctl(5'(opcode)));
`ifdef CTRL_MULDIV_EN
    assign muldiv         = op_is_muldiv(5'(opcode));
`else
    assign muldiv         = 1'b0;
`endif

    // stall_q marks T1 cycles after the first, so PC_In/ZLO_Out fire only once per fetch
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state   <= ST_IDLE;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            ctl_q   <= '0;
        end else begin
            state   <= state_next;
            stall_q <= (state == ST_T1) && !bus.Mem_Ready;
            done_q  <= done_set;
            if (state == ST_T4)
                ctl_q <= ctl_now;
        end
    end

    always_comb begin
        state_next  = state;
        done_set    = 1'b0;
        gra         = 1'b0;
        grb         = 1'b0;
        grc         = 1'b0;
        rin         = 1'b0;
        rout        = 1'b0;
        bus.PC_Out  = 1'b0;
        bus.ZLO_Out = 1'b0;
        bus.MDR_Out = 1'b0;
        bus.MAR_In  = 1'b0;
        bus.PC_In   = 1'b0;
        bus.MDR_In  = 1'b0;
        bus.IR_In   = 1'b0;
        bus.Y_In    = 1'b0;
        bus.Z_In    = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.Illegal = 1'b0;
`ifdef CTRL_MULDIV_EN
        bus.ZHI_Out = 1'b0;
        bus.LO_In   = 1'b0;
        bus.HI_In   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.Run)
                    state_next = ST_T0;
            end
            ST_T0: begin
                bus.PC_Out = 1'b1;
                bus.MAR_In = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Z_In   = 1'b1;
                state_next = ST_T1;
            end
            ST_T1: begin
                bus.Read    = 1'b1;
                bus.MDR_In  = 1'b1;
                bus.ZLO_Out = !stall_q;
                bus.PC_In   = !stall_q;
                if (bus.Mem_Ready)
                    state_next = ST_T2;
            end
            ST_T2: begin
                bus.MDR_Out = 1'b1;
                bus.IR_In   = 1'b1;
                state_next  = ST_T3;
            end
            ST_T3: begin
                if (is_halt) begin
                    state_next = ST_HALT;
                end else if (!is_alu) begin
                    bus.Illegal = 1'b1;
                    state_next  = bus.Run ? ST_T0 : ST_IDLE;
                end else begin
                    rout       = 1'b1;
                    gra        = muldiv;
                    grb        = !muldiv;
                    bus.Y_In   = 1'b1;
                    state_next = ST_T4;
                end
            end
            ST_T4: begin
                rout       = 1'b1;
                grb        = muldiv;
                grc        = !muldiv;
                bus.Z_In   = 1'b1;
                state_next = ST_T5;
            end
            ST_T5: begin
                bus.ZLO_Out = 1'b1;
`ifdef CTRL_MULDIV_EN
                if (muldiv) begin
                    bus.LO_In  = 1'b1;
                    state_next = ST_T6;
                end else
`endif
                begin
                    rin        = 1'b1;
                    gra        = 1'b1;
                    done_set   = 1'b1;
                    state_next = bus.Run ? ST_T0 : ST_IDLE;
                end
            end
`ifdef CTRL_MULDIV_EN
            ST_T6: begin
                bus.ZHI_Out = 1'b1;
                bus.HI_In   = 1'b1;
                done_set    = 1'b1;
                state_next  = bus.Run ? ST_T0 : ST_IDLE;
            end
`endif
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // CONTROL is live only in T4; elsewhere it keeps the last decoded value
    assign bus.CONTROL = (state == ST_T4) ? ctl_now : ctl_q;
    assign bus.Done    = done_q;
    assign bus.Halted  = (state == ST_HALT) || ((state == ST_T3) && is_halt);

    reg_select_encode #(
        .NREGS (NREGS)
    ) u_reg_select (
        .ra    (ra),
        .rb    (rb),
        .rc    (rc),
        .gra   (gra),
        .grb   (grb),
        .grc   (grc),
        .rin   (rin),
        .rout  (rout),
        .r_in  (bus.R_In),
        .r_out (bus.R_Out)
    );

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: builds an expected per-cycle strobe trace from instruction-level
// rules, then replays it against the DUT.
module tb_ctrl_sequencer;

    localparam int NREGS = 16;

    typedef struct packed {
        logic             pc_out;
        logic             zlo_out;
        logic             mdr_out;
        logic             mar_in;
        logic             pc_in;
        logic             mdr_in;
        logic             ir_in;
        logic             y_in;
        logic             z_in;
        logic             inc_pc;
        logic             read;
        logic [NREGS-1:0] r_in;
        logic [NREGS-1:0] r_out;
        logic [4:0]       control;
        logic             done;
        logic             illegal;
        logic             halted;
    } strobes_t;

    typedef struct {
        logic        clr;
        logic        run;
        logic        mem_ready;
        logic        chk;
        logic [31:0] ir;
        strobes_t    exp;
        string       tag;
    } step_t;

    logic     Clock;
    logic     Clear;
    step_t    steps[$];
    int       checks = 0;
    int       errors = 0;
    logic [4:0] last_ctl = '0;
    logic     pending_done = 1'b0;
    logic     cut_hit = 1'b0;
    logic     chk_next = 1'b1;
    int       instr_idx;
    int       cut_at;

    logic [4:0] legal_ops   [8] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd11};
    logic [4:0] illegal_ops [6] = '{5'd0, 5'd1, 5'd7, 5'd15, 5'd16, 5'd31};

    ctrl_sequencer_if #(.NREGS(NREGS), .CTLW(5)) bus ();

    ctrl_sequencer #(
        .NREGS (NREGS),
        .OPW   (5),
        .CTLW  (5)
    ) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [NREGS-1:0] onehot(input int idx);
        return (idx < NREGS) ? (NREGS'(1) << idx) : '0;
    endfunction

    // ALU control code per opcode; -1 undefined, -2 halt
    function automatic int ctl_code(input logic [4:0] op);
        case (op)
            5'd3:    return 0;
            5'd4:    return 1;
            5'd5:    return 2;
            5'd6:    return 3;
            5'd8:    return 4;
            5'd9:    return 5;
            5'd10:   return 6;
            5'd11:   return 7;
            5'd27:   return -2;
            default: return -1;
        endcase
    endfunction

    function automatic strobes_t blank();
        strobes_t e;
        e         = '0;
        e.control = last_ctl;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr(input logic [4:0] op);
        logic [26:0] rest;
        rest = 27'($urandom);
        return {op, rest};
    endfunction

    task automatic emit(input strobes_t e, input logic run, input logic mr,
                        input logic [31:0] ir, input logic clr, input string tag);
        step_t s;
        if (pending_done) begin
            e.done       = 1'b1;
            pending_done = 1'b0;
        end
        s.clr       = clr;
        s.run       = run;
        s.mem_ready = mr;
        s.ir        = ir;
        s.chk       = chk_next;
        s.exp       = e;
        s.tag       = tag;
        steps.push_back(s);
        if (clr) begin
            last_ctl     = '0;
            pending_done = 1'b0;
        end
    endtask

    task automatic istep(input strobes_t e, input logic run, input logic mr,
                         input logic [31:0] ir, input string tag);
        if (!cut_hit) begin
            emit(e, run, mr, ir, instr_idx == cut_at, tag);
            cut_hit = (instr_idx == cut_at);
        end
        instr_idx++;
    endtask

    task automatic add_idle(input int n, input logic last_run);
        for (int i = 0; i < n; i++)
            emit(blank(), (i == n - 1) ? last_run : 1'b0, rbit(), $urandom, 1'b0, "idle");
    endtask

    task automatic add_clear(input int n);
        for (int i = 0; i < n; i++)
            emit(blank(), 1'b0, rbit(), $urandom, 1'b1, "reset");
    endtask

    task automatic add_halt(input int n, input logic clear_last);
        strobes_t e;
        for (int i = 0; i < n; i++) begin
            e        = blank();
            e.halted = 1'b1;
            emit(e, rbit(), rbit(), $urandom, clear_last && (i == n - 1), "halt");
        end
    endtask

    // One instruction from T0; cut >= 0 asserts Clear in that cycle of the instruction
    task automatic add_instr(input logic [31:0] ir, input int stalls,
                             input logic run_after, input int cut);
        strobes_t e;
        int       code;
        code      = ctl_code(ir[31:27]);
        cut_hit   = 1'b0;
        instr_idx = 0;
        cut_at    = cut;

        e = blank(); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
        istep(e, rbit(), rbit(), $urandom, "T0");
        for (int k = 0; k <= stalls; k++) begin
            e = blank(); e.read = 1; e.mdr_in = 1;
            if (k == 0) begin
                e.zlo_out = 1;
                e.pc_in   = 1;
            end
            istep(e, rbit(), (k < stalls) ? 1'b0 : 1'b1, $urandom, "T1");
        end
        e = blank(); e.mdr_out = 1; e.ir_in = 1;
        istep(e, rbit(), rbit(), $urandom, "T2");

        if (code == -2) begin
            e = blank(); e.halted = 1;
            istep(e, rbit(), rbit(), ir, "T3_halt");
            return;
        end
        if (code == -1) begin
            e = blank(); e.illegal = 1;
            istep(e, run_after, rbit(), ir, "T3_illegal");
            return;
        end
        e = blank(); e.r_out = onehot(int'(ir[22:19])); e.y_in = 1;
        istep(e, rbit(), rbit(), ir, "T3");
        e = blank(); e.r_out = onehot(int'(ir[18:15])); e.z_in = 1; e.control = 5'(code);
        istep(e, rbit(), rbit(), ir, "T4");
        if (!cut_hit) last_ctl = 5'(code);
        e = blank(); e.zlo_out = 1; e.r_in = onehot(int'(ir[26:23]));
        istep(e, run_after, rbit(), ir, "T5");
        if (!cut_hit) pending_done = 1'b1;
    endtask

    task automatic checkOutput(input int i);
        strobes_t act;
        act.pc_out  = bus.PC_Out;
        act.zlo_out = bus.ZLO_Out;
        act.mdr_out = bus.MDR_Out;
        act.mar_in  = bus.MAR_In;
        act.pc_in   = bus.PC_In;
        act.mdr_in  = bus.MDR_In;
        act.ir_in   = bus.IR_In;
        act.y_in    = bus.Y_In;
        act.z_in    = bus.Z_In;
        act.inc_pc  = bus.IncPC;
        act.read    = bus.Read;
        act.r_in    = bus.R_In;
        act.r_out   = bus.R_Out;
        act.control = bus.CONTROL;
        act.done    = bus.Done;
        act.illegal = bus.Illegal;
        act.halted  = bus.Halted;
        checks++;
        assert (act === steps[i].exp) else begin
            errors++;
            $error("[TB] FAIL %s step %0d: observed %h expected %h",
                   steps[i].tag, i, act, steps[i].exp);
        end
    endtask

    task automatic applyStimulus();
        foreach (steps[i]) begin
            Clear         = steps[i].clr;
            bus.Run       = steps[i].run;
            bus.Mem_Ready = steps[i].mem_ready;
            bus.IR        = steps[i].ir;
            #1;
            if (steps[i].chk)
                checkOutput(i);
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        logic run_after;
        Clear         = 1'b1;
        bus.Run       = 1'b0;
        bus.Mem_Ready = 1'b0;
        bus.IR        = '0;

        chk_next = 1'b0;
        add_clear(1);
        chk_next = 1'b1;
        add_clear(1);
        add_idle(1, 1'b1);

        add_instr(32'h4A920000, 0, 1'b0, -1);
        add_idle(2, 1'b1);

        add_instr({5'd3, 4'd1, 4'd7, 4'd12, 15'h1234}, 3, 1'b1, -1);
        add_instr(rand_instr(legal_ops[$urandom_range(0, 7)]), 1, 1'b1, -1);
        add_instr(rand_instr(legal_ops[$urandom_range(0, 7)]), 0, 1'b0, -1);
        add_idle(1, 1'b1);

        add_instr(rand_instr(5'b11111), 0, 1'b1, -1);
        add_instr(rand_instr(legal_ops[$urandom_range(0, 7)]), 0, 1'b0, -1);
        add_idle(1, 1'b1);

        add_instr({5'd5, 4'd3, 4'd9, 4'd14, 15'h0}, 1, 1'b1, 5);
        add_idle(2, 1'b1);
        add_instr(rand_instr(legal_ops[$urandom_range(0, 7)]), 3, 1'b0, 2);
        add_idle(1, 1'b1);

        for (int n = 0; n < 12; n++) begin
            run_after = rbit();
            if ($urandom_range(0, 3) == 0)
                add_instr(rand_instr(illegal_ops[$urandom_range(0, 5)]),
                          $urandom_range(0, 3), run_after, -1);
            else
                add_instr(rand_instr(legal_ops[$urandom_range(0, 7)]),
                          $urandom_range(0, 3), run_after, -1);
            if (!run_after)
                add_idle(1 + $urandom_range(0, 2), 1'b1);
        end

        add_instr(32'hD8000000, 2, 1'b0, -1);
        add_halt(6, 1'b1);
        add_idle(2, 1'b0);

        $display("[TB] replaying %0d cycles", steps.size());
        applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Hardwired control unit upstream of the Datapath; produces every bus-drive, register-load and ALU-control strobe the datapath consumes.
- Runs the fetch sequence T0–T2, decodes IR, and runs the three-cycle execute sequence T3–T5 for register-to-register ALU and shift instructions.
- Replaces bench-driven strobes so the datapath runs instructions autonomously.

Parameters:
- NREGS, 16, number of general registers; width of the one-hot R_In/R_Out buses.
- OPW, 5, opcode width taken from IR[31:27].
- CTLW, 5, width of the ALU CONTROL output.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Clear  in  1  synchronous active-high reset.
- Run  in  1  level; allows sequencing to start and continue.
- IR  in  32  instruction register from the datapath; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- Mem_Ready  in  1  memory read complete; sampled in T1.
- PC_Out, ZLO_Out, MDR_Out  out  1 each  bus drive strobes.
- MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In, IncPC, Read  out  1 each  load and control strobes.
- R_In  out  NREGS  one-hot general-register load.
- R_Out  out  NREGS  one-hot general-register bus drive.
- CONTROL  out  CTLW  ALU operation select.
- Done  out  1  one-cycle pulse in the cycle after T5 completes.
- Illegal  out  1  one-cycle pulse on an undefined opcode.
- Halted  out  1  sticky flag.

Behaviour:
- Reset: on Clock with Clear=1, state goes to IDLE. Every output is 0, including CONTROL=0 and Halted=0.
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT.
- Strobes are a Moore function of state and the latched IR fields. Each strobe is held for the full cycle of its state and is never asserted in two consecutive states unless listed.
- IDLE: no strobes. Go to T0 when Run=1.
- T0: PC_Out, MAR_In, IncPC, Z_In. Go to T1.
- T1: ZLO_Out, PC_In only on the first cycle of T1; Read and MDR_In on every cycle of T1.
  - Stay in T1 while Mem_Ready=0.
  - Go to T2 on the cycle Mem_Ready=1.
  - PC_In must not repeat during a memory stall.
- T2: MDR_Out, IR_In. IR is valid from T3 onward.
- T3: opcode decoded from IR.
  - HALT opcode 11011: go to HALT with no strobes.
  - Undefined opcode: pulse Illegal, then go to T0 if Run=1, else IDLE.
  - Otherwise drive R_Out[Rb] and Y_In.
- T4: R_Out[Rc], Z_In, CONTROL = op_to_ctl(opcode).
- T5: ZLO_Out, R_In[Ra]. Then Done pulses and the next state is T0 if Run=1, else IDLE.
- CONTROL holds its last value outside T4; the datapath ignores it then.
- Nominal instruction latency is 6 cycles (T0–T5) with Mem_Ready high in the first T1 cycle. Each stall cycle adds 1.
- HALT: all strobes 0, Halted=1. Left only by Clear.
- Run dropping mid-instruction: the current instruction completes; Run is sampled only in IDLE and at the end of T5 or the Illegal exit.
- Clear mid-instruction, including during a T1 stall: returns to IDLE next edge with all strobes 0. Partial results are discarded.
- Register index ≥ NREGS: no R_In/R_Out bit is set.

Optional Feature:
- CTRL_MULDIV_EN defined: MUL 01111 and DIV 10000 are legal.
  - T3: R_Out[Ra], Y_In.
  - T4: R_Out[Rb], CONTROL from op_to_ctl, Z_In.
  - T5: ZLO_Out, LO_In.
  - T6: ZHI_Out, HI_In, then Done.
  - Extra ports: ZHI_Out, LO_In, HI_In (out 1 each).
- Undefined: MUL/DIV raise Illegal, no T6 state exists, and the extra ports are absent.

Decomposition:
- Package ctrl_pkg: state enum; opcode constants; op_to_ctl table, including ADD 00011→00000, SHR 01000→00100, SHL 01001→00101; field bit positions.
- One sub-module, reg_select_encode: IR fields plus gra/grb/grc/rin/rout selects in, one-hot R_In/R_Out out.

Test Plan:
- Clear=1 for 2 cycles, then Run=1, IR loaded 0x4A920000 (SHL R5,R2,R4), Mem_Ready tied 1:
  - T3: R_Out=0x0004 with Y_In.
  - T4: R_Out=0x0010, CONTROL=00101, Z_In.
  - T5: R_In=0x0020, ZLO_Out.
  - Done 6 cycles after T0.
- Mem_Ready low for 3 cycles in T1: Read and MDR_In high for 4 cycles, PC_In high for 1 cycle only, latency 9.
- Run held 1 across two instructions: T0 immediately follows T5 with no IDLE cycle; Done pulses twice.
- IR=0xD8000000 (HALT): Halted=1 and all strobes 0 from T3. Run toggling has no effect. Clear restores IDLE and Halted=0.
- Undefined opcode 11111: Illegal pulses once, no R_In bit ever set, returns to T0.
- Clear asserted during T4: next cycle is IDLE, Z_In=0, CONTROL=0, no R_In write.
